// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register that feeds the ALU.
// Forwards results from EX/MEM and MEM/WB, then selects Pc or Imm.
// Masks shift amounts and registers AluOp, A and B.
// Inserts one bubble for a load-use hazard.
// Honours downstream Stall and Flush.
module alu_operand_stage #(
    parameter int n     = 32,
    parameter int RADDR = 5
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       InAluOp,
    input  logic [RADDR-1:0] Rs1,
    input  logic [RADDR-1:0] Rs2,
    input  logic [n-1:0]     Rs1Data,
    input  logic [n-1:0]     Rs2Data,
    input  logic [n-1:0]     Imm,
    input  logic [n-1:0]     Pc,
    input  logic             SrcASel,
    input  logic             SrcBSel,
    input  logic             UsesRs1,
    input  logic             UsesRs2,
    input  logic [RADDR-1:0] InRd,
    input  logic             InIsLoad,
    input  logic             MemWe,
    input  logic [RADDR-1:0] MemRd,
    input  logic [n-1:0]     MemData,
    input  logic             WbWe,
    input  logic [RADDR-1:0] WbRd,
    input  logic [n-1:0]     WbData,
    input  logic             Stall,
    input  logic             Flush,
    output logic [3:0]       AluOp,
    output logic [n-1:0]     A,
    output logic [n-1:0]     B,
    output logic [RADDR-1:0] OutRd,
    output logic             OutIsLoad,
    output logic             OutValid
);

    logic [3:0]       r_aluOp;
    logic [n-1:0]     r_a;
    logic [n-1:0]     r_b;
    logic [RADDR-1:0] r_rd;
    logic             r_isLoad;
    logic             r_valid;

    logic [n-1:0]     w_fwd1;
    logic [n-1:0]     w_fwd2;
    logic [n-1:0]     w_srcA;
    logic [n-1:0]     w_srcBRaw;
    logic [n-1:0]     w_srcB;
    logic             w_isShift;
    logic             w_loadUse;

    // The youngest producer (EX/MEM) wins over MEM/WB; x0 is never forwarded
    function automatic logic [n-1:0] forwardSource(
        input logic [RADDR-1:0] rs,
        input logic [n-1:0]     regData,
        input logic             memWe,
        input logic [RADDR-1:0] memRd,
        input logic [n-1:0]     memData,
        input logic             wbWe,
        input logic [RADDR-1:0] wbRd,
        input logic [n-1:0]     wbData
    );
        logic [n-1:0] result;
        result = regData;
        if (rs != '0) begin
            if (memWe && (memRd == rs)) begin
                result = memData;
            end else if (wbWe && (wbRd == rs)) begin
                result = wbData;
            end
        end
        return result;
    endfunction

    // Resolve forwarded sources, then apply the Pc/Imm select and the shift-amount mask
    always_comb begin
        w_fwd1    = forwardSource(Rs1, Rs1Data, MemWe, MemRd, MemData, WbWe, WbRd, WbData);
        w_fwd2    = forwardSource(Rs2, Rs2Data, MemWe, MemRd, MemData, WbWe, WbRd, WbData);
        w_srcA    = SrcASel ? Pc  : w_fwd1;
        w_srcBRaw = SrcBSel ? Imm : w_fwd2;
        w_isShift = (InAluOp == 4'b0010) || (InAluOp == 4'b1010) || (InAluOp == 4'b1011);
        w_srcB    = w_srcBRaw;
        if (w_isShift) begin
            w_srcB = {{(n-5){1'b0}}, w_srcBRaw[4:0]};
        end
    end

    // A load sitting in the output register cannot feed a dependent instruction yet
    always_comb begin
        w_loadUse = r_valid && r_isLoad && (r_rd != '0) &&
                    ((UsesRs1 && (Rs1 == r_rd)) || (UsesRs2 && (Rs2 == r_rd)));
        InReady   = !Stall && !w_loadUse;
    end

    // Output register: flush beats stall, stall beats bubble, bubble beats capture
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_aluOp  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_isLoad <= 1'b0;
            r_valid  <= 1'b0;
        end else if (Flush) begin
            r_valid  <= 1'b0;
        end else if (Stall) begin
            r_valid  <= r_valid;
        end else if (w_loadUse) begin
            r_valid  <= 1'b0;
            r_isLoad <= 1'b0;
        end else if (InValid) begin
            r_aluOp  <= InAluOp;
            r_a      <= w_srcA;
            r_b      <= w_srcB;
            r_rd     <= InRd;
            r_isLoad <= InIsLoad;
            r_valid  <= 1'b1;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    assign AluOp     = r_aluOp;
    assign A         = r_a;
    assign B         = r_b;
    assign OutRd     = r_rd;
    assign OutIsLoad = r_isLoad;
    assign OutValid  = r_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with hand-computed expectations for alu_operand_stage.
module tb_alu_operand_stage;

    logic        clock = 1'b0;
    logic        nReset;
    logic        InValid;
    logic        InReady;
    logic [3:0]  InAluOp;
    logic [4:0]  Rs1, Rs2;
    logic [31:0] Rs1Data, Rs2Data, Imm, Pc;
    logic        SrcASel, SrcBSel, UsesRs1, UsesRs2;
    logic [4:0]  InRd;
    logic        InIsLoad;
    logic        MemWe;
    logic [4:0]  MemRd;
    logic [31:0] MemData;
    logic        WbWe;
    logic [4:0]  WbRd;
    logic [31:0] WbData;
    logic        Stall, Flush;
    logic [3:0]  AluOp;
    logic [31:0] A, B;
    logic [4:0]  OutRd;
    logic        OutIsLoad, OutValid;

    int checkCount = 0;
    int errorCount = 0;

    alu_operand_stage #(.n(32), .RADDR(5)) dut (
        .clock(clock), .nReset(nReset), .InValid(InValid), .InReady(InReady),
        .InAluOp(InAluOp), .Rs1(Rs1), .Rs2(Rs2), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
        .Imm(Imm), .Pc(Pc), .SrcASel(SrcASel), .SrcBSel(SrcBSel),
        .UsesRs1(UsesRs1), .UsesRs2(UsesRs2), .InRd(InRd), .InIsLoad(InIsLoad),
        .MemWe(MemWe), .MemRd(MemRd), .MemData(MemData),
        .WbWe(WbWe), .WbRd(WbRd), .WbData(WbData),
        .Stall(Stall), .Flush(Flush),
        .AluOp(AluOp), .A(A), .B(B), .OutRd(OutRd), .OutIsLoad(OutIsLoad), .OutValid(OutValid)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        InValid = 0; InAluOp = 0; Rs1 = 0; Rs2 = 0; Rs1Data = 0; Rs2Data = 0;
        Imm = 0; Pc = 0; SrcASel = 0; SrcBSel = 0; UsesRs1 = 0; UsesRs2 = 0;
        InRd = 0; InIsLoad = 0; MemWe = 0; MemRd = 0; MemData = 0;
        WbWe = 0; WbRd = 0; WbData = 0; Stall = 0; Flush = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] rs1Data,
                                 input logic [4:0] rs2, input logic [31:0] rs2Data, input logic [31:0] imm,
                                 input logic [31:0] pc, input logic selA, input logic selB,
                                 input logic uses1, input logic uses2, input logic [4:0] rd,
                                 input logic isLoad);
        InValid = 1; InAluOp = op; Rs1 = rs1; Rs1Data = rs1Data; Rs2 = rs2; Rs2Data = rs2Data;
        Imm = imm; Pc = pc; SrcASel = selA; SrcBSel = selB; UsesRs1 = uses1; UsesRs2 = uses2;
        InRd = rd; InIsLoad = isLoad;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_aluop"},  {28'd0, AluOp}, 32'd0);
        checkOutput({tag, "_a"},      A, 32'd0);
        checkOutput({tag, "_b"},      B, 32'd0);
        checkOutput({tag, "_rd"},     {27'd0, OutRd}, 32'd0);
        checkOutput({tag, "_isload"}, {31'd0, OutIsLoad}, 32'd0);
        checkOutput({tag, "_valid"},  {31'd0, OutValid}, 32'd0);
    endtask

    initial begin
        clearInputs();
        nReset = 0;
        #2;
        checkAllZero("reset");
        stepCycle();
        stepCycle();
        nReset = 1;
        stepCycle();
        checkOutput("post_reset_idle", {31'd0, OutValid}, 32'd0);

        // Forwarding priority: EX/MEM beats MEM/WB
        MemWe = 1; MemRd = 5; MemData = 32'hAAAA0000;
        WbWe = 1; WbRd = 5; WbData = 32'h00001111;
        applyStimulus(4'b0000, 5'd5, 32'h12345678, 5'd6, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 5'd1, 0);
        checkOutput("ready_idle", {31'd0, InReady}, 32'd1);
        stepCycle();
        checkOutput("fwd_mem_a", A, 32'hAAAA0000);
        checkOutput("fwd_mem_valid", {31'd0, OutValid}, 32'd1);
        MemWe = 0;
        stepCycle();
        checkOutput("fwd_wb_a", A, 32'h00001111);
        // x0 never forwarded even when producers name it
        MemWe = 1; MemRd = 0; WbRd = 0;
        applyStimulus(4'b0000, 5'd0, 32'hCAFE0000, 5'd6, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 5'd1, 0);
        stepCycle();
        checkOutput("fwd_x0_a", A, 32'hCAFE0000);
        // Pc select overrides a forwarded source; WB forwarding on rs2
        MemWe = 1; MemRd = 5; WbWe = 1; WbRd = 9; WbData = 32'h0BEEF009;
        applyStimulus(4'b0001, 5'd5, 32'h0, 5'd9, 32'h77, 32'h0, 32'h00400010, 1, 0, 1, 1, 5'd2, 0);
        stepCycle();
        checkOutput("pc_sel_a", A, 32'h00400010);
        checkOutput("fwd_wb_b", B, 32'h0BEEF009);
        checkOutput("aluop_reg", {28'd0, AluOp}, 32'd1);
        MemWe = 0; WbWe = 0;

        // Shift-amount mask
        applyStimulus(4'b0010, 5'd1, 32'h0, 5'd2, 32'h0, 32'hFFFFFFE3, 32'h0, 0, 1, 1, 0, 5'd3, 0);
        stepCycle();
        checkOutput("shift_imm_b", B, 32'h00000003);
        applyStimulus(4'b0000, 5'd1, 32'h0, 5'd2, 32'h0, 32'hFFFFFFE3, 32'h0, 0, 1, 1, 0, 5'd3, 0);
        stepCycle();
        checkOutput("noshift_imm_b", B, 32'hFFFFFFE3);
        applyStimulus(4'b1010, 5'd1, 32'h0, 5'd2, 32'h12345687, 32'h0, 32'h0, 0, 0, 1, 1, 5'd3, 0);
        stepCycle();
        checkOutput("shift_rs2_b", B, 32'h00000007);
        applyStimulus(4'b1011, 5'd1, 32'h0, 5'd2, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 1, 1, 5'd3, 0);
        stepCycle();
        checkOutput("sra_rs2_b", B, 32'h0000001F);

        // Load-use: load x7, then an add reading x7 through rs2
        applyStimulus(4'b0000, 5'd1, 32'h00000100, 5'd2, 32'h0, 32'h00000004, 32'h0, 0, 1, 1, 0, 5'd7, 1);
        stepCycle();
        checkOutput("load_valid", {31'd0, OutValid}, 32'd1);
        checkOutput("load_isload", {31'd0, OutIsLoad}, 32'd1);
        checkOutput("load_rd", {27'd0, OutRd}, 32'd7);
        MemWe = 1; MemRd = 7; MemData = 32'h600DF00D;
        applyStimulus(4'b0000, 5'd3, 32'h00000011, 5'd7, 32'h00000BAD, 32'h0, 32'h0, 0, 0, 1, 1, 5'd8, 0);
        checkOutput("loaduse_ready", {31'd0, InReady}, 32'd0);
        stepCycle();
        checkOutput("bubble_valid", {31'd0, OutValid}, 32'd0);
        checkOutput("bubble_isload", {31'd0, OutIsLoad}, 32'd0);
        checkOutput("bubble_hold_b", B, 32'h00000004);
        checkOutput("after_bubble_ready", {31'd0, InReady}, 32'd1);
        stepCycle();
        checkOutput("use_valid", {31'd0, OutValid}, 32'd1);
        checkOutput("use_b", B, 32'h600DF00D);
        checkOutput("use_rd", {27'd0, OutRd}, 32'd8);
        MemWe = 0;

        // Stall holds for three cycles, then flush under stall kills it
        applyStimulus(4'b0000, 5'd3, 32'h00000011, 5'd4, 32'h00000022, 32'h0, 32'h0, 0, 0, 1, 1, 5'd3, 0);
        stepCycle();
        Stall = 1;
        applyStimulus(4'b0001, 5'd3, 32'h00000099, 5'd4, 32'h00000088, 32'h0, 32'h0, 0, 0, 1, 1, 5'd9, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_ready", {31'd0, InReady}, 32'd0);
            stepCycle();
            checkOutput("stall_a", A, 32'h00000011);
            checkOutput("stall_b", B, 32'h00000022);
            checkOutput("stall_valid", {31'd0, OutValid}, 32'd1);
        end
        Flush = 1;
        stepCycle();
        checkOutput("flush_stall_valid", {31'd0, OutValid}, 32'd0);
        Flush = 0; Stall = 0;

        // Stall with a pending load-use holds instead of bubbling; flush blocks capture
        applyStimulus(4'b0000, 5'd1, 32'h0, 5'd2, 32'h0, 32'h8, 32'h0, 0, 1, 0, 0, 5'd7, 1);
        stepCycle();
        Stall = 1;
        applyStimulus(4'b0000, 5'd7, 32'h0, 5'd2, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 5'd8, 0);
        checkOutput("stall_lu_ready", {31'd0, InReady}, 32'd0);
        stepCycle();
        checkOutput("stall_lu_valid", {31'd0, OutValid}, 32'd1);
        checkOutput("stall_lu_isload", {31'd0, OutIsLoad}, 32'd1);
        Stall = 0; Flush = 1;
        stepCycle();
        checkOutput("flush_valid", {31'd0, OutValid}, 32'd0);
        checkOutput("flush_no_capture_rd", {27'd0, OutRd}, 32'd7);
        Flush = 0;

        // Throughput: eight back-to-back independent ops
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0000, 5'd1, 32'h00001000 + i, 5'd2, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0,
                          5'(i + 10), 0);
            stepCycle();
            checkOutput("tput_valid", {31'd0, OutValid}, 32'd1);
            checkOutput("tput_a", A, 32'h00001000 + i);
            checkOutput("tput_rd", {27'd0, OutRd}, 32'(i + 10));
        end
        InValid = 0;
        stepCycle();
        checkOutput("tput_drain_valid", {31'd0, OutValid}, 32'd0);

        // Async reset asserted mid-cycle while a capture is in flight
        applyStimulus(4'b0011, 5'd1, 32'hDEAD0000, 5'd2, 32'h5, 32'h0, 32'h0, 0, 0, 1, 1, 5'd4, 1);
        stepCycle();
        checkOutput("pre_reset_a", A, 32'hDEAD0000);
        #2;
        nReset = 0;
        #1;
        checkAllZero("async_reset");
        stepCycle();
        nReset = 1;
        clearInputs();
        stepCycle();
        checkOutput("release_idle1", {31'd0, OutValid}, 32'd0);
        stepCycle();
        checkOutput("release_idle2", {31'd0, OutValid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
